// File: rtl/controle_vai_vem_pkg.sv
// Shared definitions for the back-and-forth position controller.
// The display logic uses the same state codes and debug width.
package controle_vai_vem_pkg;

  localparam int DB_W    = 3;
  localparam int SWEEP_W = 8;

  typedef enum logic [DB_W-1:0] {
    OCIOSO    = 3'd0,
    CENTRA    = 3'd1,
    MANUAL    = 3'd2,
    VARRE_VAI = 3'd3,
    VARRE_VEM = 3'd4
  } estado_t;

endpackage

// File: rtl/controle_vai_vem_if.sv
// Request/command bundle between the controller and its position counter.
// The master side is the user/counter side; the slave side is the controller.
interface controle_vai_vem_if #(parameter int N = 7) ();
  import controle_vai_vem_pkg::*;

  logic               iniciar;
  logic               parar;
  logic               modo;
  logic               btn_vai;
  logic               btn_vem;
  logic [N-1:0]       Q;
  logic               set_pos;
  logic [N-1:0]       D;
  logic               vai;
  logic               vem;
  logic               enable_mov;
  logic               ocupado;
  logic [SWEEP_W-1:0] varreduras;
  logic [DB_W-1:0]    db_estado;

  modport master (
    output iniciar, parar, modo, btn_vai, btn_vem, Q,
    input  set_pos, D, vai, vem, enable_mov, ocupado, varreduras, db_estado
  );

  modport slave (
    input  iniciar, parar, modo, btn_vai, btn_vem, Q,
    output set_pos, D, vai, vem, enable_mov, ocupado, varreduras, db_estado
  );

endinterface

// File: rtl/controle_vai_vem_gerador_tick.sv
// Movement prescaler: counts 0..T-1 while enabled and emits a registered
// one-clock tick after the T-1 count.
module gerador_tick #(
  parameter int T = 50
) (
  input  logic clock,
  input  logic zera_as,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (T > 1) ? $clog2(T) : 1;
  localparam logic [CW-1:0] LAST = CW'(T - 1);

  logic [CW-1:0] count_q, count_d;
  logic          tick_q, tick_d;

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (count_q == LAST) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/controle_vai_vem.sv
// Controller that centres a position counter and then either follows the
// manual buttons or sweeps it end to end, counting completed sweeps.
module controle_vai_vem
  import controle_vai_vem_pkg::*;
#(
  parameter int M = 100,
  parameter int N = 7,
  parameter int T = 50
) (
  input  logic               clock,
  input  logic               zera_as,
  controle_vai_vem_if.slave  bus
);

  localparam logic [N-1:0]       Q_MAX    = N'(M - 1);
  localparam logic [N-1:0]       D_CENTRO = N'(M / 2 - 1);
  localparam logic [SWEEP_W-1:0] SAT      = {SWEEP_W{1'b1}};

  estado_t            state_q, state_d;
  logic [SWEEP_W-1:0] varreduras_q, varreduras_d;
  logic               set_pos, vai, vem;
  logic               mov_ativo, tick_clear, enable_mov;

  always_comb begin
    state_d = state_q;
    set_pos = 1'b0;
    vai     = 1'b0;
    vem     = 1'b0;
    case (state_q)
      OCIOSO:    if (bus.iniciar && !bus.parar) state_d = CENTRA;
      CENTRA: begin
        set_pos = 1'b1;
        state_d = bus.modo ? VARRE_VAI : MANUAL;
      end
      MANUAL: begin
        vai = bus.btn_vai && !bus.btn_vem;
        vem = bus.btn_vem && !bus.btn_vai;
      end
      VARRE_VAI: begin
        vai = 1'b1;
        if (bus.Q == Q_MAX) state_d = VARRE_VEM;
      end
      VARRE_VEM: begin
        vem = 1'b1;
        if (bus.Q == '0) state_d = VARRE_VAI;
      end
      default:   state_d = OCIOSO;
    endcase
    // Stop wins over every other transition, including end-of-travel turns.
    if (bus.parar && state_q != OCIOSO) state_d = OCIOSO;
  end

  always_comb begin
    varreduras_d = varreduras_q;
    if (state_d == CENTRA) begin
      varreduras_d = '0;
    end else if (state_q == VARRE_VEM && state_d == VARRE_VAI && varreduras_q != SAT) begin
      varreduras_d = varreduras_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      state_q      <= OCIOSO;
      varreduras_q <= '0;
    end else begin
      state_q      <= state_d;
      varreduras_q <= varreduras_d;
    end
  end

  assign mov_ativo  = (state_q == MANUAL) || (state_q == VARRE_VAI) || (state_q == VARRE_VEM);
  assign tick_clear = (state_q == OCIOSO) || (state_q == CENTRA);

  gerador_tick #(.T(T)) u_gerador_tick (
    .clock   (clock),
    .zera_as (zera_as),
    .clear   (tick_clear),
    .enable  (mov_ativo),
    .tick    (enable_mov)
  );

  assign bus.set_pos    = set_pos;
  assign bus.D          = D_CENTRO;
  assign bus.vai        = vai;
  assign bus.vem        = vem;
  assign bus.enable_mov = enable_mov;
  assign bus.ocupado    = (state_q != OCIOSO);
  assign bus.varreduras = varreduras_q;
  assign bus.db_estado  = state_q;

endmodule
